// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// dmem_arb_pkg : shared types and defaults for the data-memory arbiter | Rev 1.0
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int DEFAULT_MAX_BURST = 4;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// rr_arbiter2 : two-input round-robin picker, ties go to the side not last granted | Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic   req_cpu,
  input  logic   req_dbg,
  input  owner_e last_grant,
  output logic   gnt_cpu,
  output logic   gnt_dbg
);

  always_comb begin
    gnt_cpu = 1'b0;
    gnt_dbg = 1'b0;
    if (req_cpu && req_dbg) begin
      gnt_cpu = (last_grant != OWN_CPU);
      gnt_dbg = (last_grant == OWN_CPU);
    end else begin
      gnt_cpu = req_cpu;
      gnt_dbg = req_dbg;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : shares one data-memory port between CPU and debug, with bounded debug bursts | Rev 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  input  logic                  dbg_lock,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int            CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  state_e             state, state_next;
  owner_e             last_grant, last_next;
  owner_e             rd_tag, rd_tag_next;
  logic [CNT_W-1:0]   burst_cnt, cnt_next;

  logic cpu_req_act, dbg_req_act;
  logic rr_cpu, rr_dbg;

  // Grants are suppressed while reset is held so the port is quiet immediately.
  assign cpu_req_act = cpu_req & ~reset;
  assign dbg_req_act = dbg_req & ~reset;

  rr_arbiter2 u_rr (
    .req_cpu    (cpu_req_act),
    .req_dbg    (dbg_req_act),
    .last_grant (last_grant),
    .gnt_cpu    (rr_cpu),
    .gnt_dbg    (rr_dbg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= OWN_DBG;
      burst_cnt  <= '0;
      rd_tag     <= OWN_NONE;
    end else begin
      state      <= state_next;
      last_grant <= last_next;
      burst_cnt  <= cnt_next;
      rd_tag     <= rd_tag_next;
    end
  end

  always_comb begin
    state_next  = state;
    last_next   = last_grant;
    rd_tag_next = OWN_NONE;
    cnt_next    = burst_cnt;
    cpu_gnt     = 1'b0;
    dbg_gnt     = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    if (state == BURST && dbg_req_act) begin
      dbg_gnt = 1'b1;
    end else begin
      cpu_gnt = rr_cpu;
      dbg_gnt = rr_dbg;
    end

    if (cpu_gnt) begin
      mem_en      = 1'b1;
      mem_we      = cpu_we;
      mem_addr    = cpu_addr;
      mem_wdata   = cpu_wdata;
      last_next   = OWN_CPU;
      rd_tag_next = cpu_we ? OWN_NONE : OWN_CPU;
    end else if (dbg_gnt) begin
      mem_en      = 1'b1;
      mem_we      = dbg_we;
      mem_addr    = dbg_addr;
      mem_wdata   = dbg_wdata;
      last_next   = OWN_DBG;
      rd_tag_next = dbg_we ? OWN_NONE : OWN_DBG;
    end

    // Lock only extends ownership until the count hits MAX_BURST; then the CPU gets its turn.
    if (dbg_gnt && dbg_lock) begin
      cnt_next = (state == BURST) ? burst_cnt + 1'b1 : CNT_W'(1);
      if (cnt_next == MAX_CNT) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else begin
        state_next = BURST;
      end
    end else begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign cpu_rvalid = (rd_tag == OWN_CPU);
  assign dbg_rvalid = (rd_tag == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

`default_nettype wire
